bus_gen_arbiter: RTL and testbench



---
 rtl/bus_gen_arbiter_if.sv | 16 +
 rtl/bus_gen_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_gen_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bus_gen_arbiter_if.sv
// Shared-bus bundle between the device FIFO front-ends and the arbiter fabric.
// The master modport is the arbiter side; the slave modport is the device side.
interface bus_gen_arbiter_if #(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [bits-1:0][drvrs-1:0]              pndng;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [bits-1:0][drvrs-1:0]              pop;
    logic [bits-1:0][drvrs-1:0]              push;
    logic [bits-1:0][pckg_sz-1:0]            D_push;

    modport master (input pndng, input D_pop, output pop, output push, output D_push);
    modport slave  (output pndng, output D_pop, input pop, input push, input D_push);
endinterface

// File: rtl/bus_gen_arbiter.sv
// Per-bus round-robin arbiter: pops one packet from a pending device, then pushes it to the
// device named by the packet's top byte (or to all other devices on a broadcast ID).
module bus_gen_arbiter #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    bus_gen_arbiter_if.master bus
);
    localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] PUSH = 2'd2;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        logic [1:0]         state_r;
        logic [PW-1:0]      win_r;
        logic [PW-1:0]      rr_r;
        logic [pckg_sz-1:0] pkt_r;
        logic [drvrs-1:0]   push_r;
        logic               any_pend;
        logic [PW-1:0]      pick;
        logic [7:0]         dest;
        logic [drvrs-1:0]   push_nxt;
        logic [drvrs-1:0]   pop_now;
        logic [PW-1:0]      rr_nxt;

        // Winner search: scan from the farthest offset back so the nearest pending index after rr wins.
        always_comb begin
            int idx;
            pick     = rr_r;
            any_pend = 1'b0;
            for (int k = drvrs - 1; k >= 0; k--) begin
                idx = int'(rr_r) + k;
                if (idx >= drvrs) begin
                    idx = idx - drvrs;
                end else begin
                    idx = idx;
                end
                if (bus.pndng[b][idx]) begin
                    pick     = PW'(idx);
                    any_pend = 1'b1;
                end else begin
                    pick     = pick;
                    any_pend = any_pend;
                end
            end
        end

        // Destination decode of the winner's FIFO head, and the pop strobe while in POP.
        always_comb begin
            dest     = bus.D_pop[b][win_r][pckg_sz-1 -: 8];
            push_nxt = {drvrs{1'b0}};
            pop_now  = {drvrs{1'b0}};
            for (int j = 0; j < drvrs; j++) begin
                if (dest == broadcast) begin
                    push_nxt[j] = (j != int'(win_r));
                end else begin
                    push_nxt[j] = (int'(dest) == j);
                end
                pop_now[j] = (state_r == POP) && (int'(win_r) == j) && bus.pndng[b][j];
            end
            if (win_r == PW'(drvrs - 1)) begin
                rr_nxt = {PW{1'b0}};
            end else begin
                rr_nxt = win_r + PW'(1);
            end
        end

        // Arbitration FSM; push and the bus data are registered, a reset discards any latched packet.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= IDLE;
                win_r   <= {PW{1'b0}};
                rr_r    <= {PW{1'b0}};
                pkt_r   <= {pckg_sz{1'b0}};
                push_r  <= {drvrs{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        push_r <= {drvrs{1'b0}};
                        if (any_pend) begin
                            win_r   <= pick;
                            state_r <= POP;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    POP: begin
                        if (bus.pndng[b][win_r]) begin
                            pkt_r   <= bus.D_pop[b][win_r];
                            push_r  <= push_nxt;
                            state_r <= PUSH;
                        end else begin
                            push_r  <= {drvrs{1'b0}};
                            state_r <= IDLE;
                        end
                    end
                    PUSH: begin
                        push_r  <= {drvrs{1'b0}};
                        rr_r    <= rr_nxt;
                        state_r <= IDLE;
                    end
                    default: begin
                        push_r  <= {drvrs{1'b0}};
                        state_r <= IDLE;
                    end
                endcase
            end
        end

        assign bus.pop[b]    = pop_now;
        assign bus.push[b]   = push_r;
        assign bus.D_push[b] = pkt_r;
    end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Directed bench for bus_gen_arbiter with one bus of four devices.
module tb_bus_gen_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    bus_gen_arbiter_if #(.bits(1), .drvrs(4), .pckg_sz(16)) bus ();

    bus_gen_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pndng[0] = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        bus.pndng[0] = 4'b1111;
        for (int i = 0; i < 4; i++) bus.D_pop[0][i] = 16'h0000;

        // 1: reset held three cycles with everything pending
        tick();
        tick();
        tick();
        chk("rst_pop",   32'(bus.pop[0]),    32'h0);
        chk("rst_push",  32'(bus.push[0]),   32'h0);
        chk("rst_dpush", 32'(bus.D_push[0]), 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_pop0", 32'(bus.pop[0]), 32'h0);
        tick();
        chk("rel_pop1", 32'(bus.pop[0]), 32'b0001);

        // 2: unicast from dev1 to dev2
        do_reset();
        bus.D_pop[0][1] = 16'h02AB;
        bus.pndng[0]    = 4'b0010;
        #1;
        chk("uc_idle_pop", 32'(bus.pop[0]), 32'h0);
        tick();
        chk("uc_pop",      32'(bus.pop[0]),  32'b0010);
        chk("uc_pop_push", 32'(bus.push[0]), 32'h0);
        tick();
        bus.pndng[0] = 4'b0000;
        chk("uc_push",       32'(bus.push[0]),   32'b0100);
        chk("uc_dpush",      32'(bus.D_push[0]), 32'h02AB);
        chk("uc_push_nopop", 32'(bus.pop[0]),    32'h0);
        tick();
        chk("uc_after_push",  32'(bus.push[0]),   32'h0);
        chk("uc_dpush_hold",  32'(bus.D_push[0]), 32'h02AB);

        // 3: broadcast from dev0, pointer wraps from 2 back to 0
        bus.D_pop[0][0] = 16'hFF55;
        bus.pndng[0]    = 4'b0001;
        tick();
        chk("bc_pop", 32'(bus.pop[0]), 32'b0001);
        tick();
        bus.pndng[0] = 4'b0000;
        chk("bc_push",  32'(bus.push[0]),   32'b1110);
        chk("bc_dpush", 32'(bus.D_push[0]), 32'hFF55);
        chk("bc_pop1",  32'(bus.pop[0]),    32'h0);
        tick();
        chk("bc_push_end", 32'(bus.push[0]), 32'h0);
        chk("bc_pop2",     32'(bus.pop[0]),  32'h0);

        // 4: round-robin with all devices pending; device i addresses device (i+1)%4
        do_reset();
        for (int i = 0; i < 4; i++) bus.D_pop[0][i] = {8'((i + 1) % 4), 8'(8'h10 + i)};
        bus.pndng[0] = 4'b1111;
        for (int n = 0; n < 15; n++) begin
            tick();
            chk($sformatf("rr_pop_%0d", n), 32'(bus.pop[0]),
                (n % 3 == 0) ? (32'h1 << ((n / 3) % 4)) : 32'h0);
            chk($sformatf("rr_push_%0d", n), 32'(bus.push[0]),
                (n % 3 == 1) ? (32'h1 << ((((n / 3) % 4) + 1) % 4)) : 32'h0);
        end

        // 5: invalid destination from dev3 is dropped, then dev2 is served
        do_reset();
        bus.D_pop[0][3] = 16'h0712;
        bus.D_pop[0][2] = 16'h0133;
        bus.pndng[0]    = 4'b1000;
        tick();
        chk("inv_pop", 32'(bus.pop[0]), 32'b1000);
        tick();
        bus.pndng[0] = 4'b0100;
        chk("inv_push",  32'(bus.push[0]),   32'h0);
        chk("inv_dpush", 32'(bus.D_push[0]), 32'h0712);
        tick();
        chk("inv_idle_push", 32'(bus.push[0]), 32'h0);
        tick();
        chk("inv_next_pop", 32'(bus.pop[0]), 32'b0100);
        tick();
        bus.pndng[0] = 4'b0000;
        chk("inv_next_push",  32'(bus.push[0]),   32'b0010);
        chk("inv_next_dpush", 32'(bus.D_push[0]), 32'h0133);

        // 6: reset lands on the edge that would enter PUSH
        do_reset();
        bus.D_pop[0][1] = 16'h01CC;
        bus.pndng[0]    = 4'b0010;
        tick();
        chk("rp_pop", 32'(bus.pop[0]), 32'b0010);
        reset = 1'b1;
        tick();
        bus.pndng[0] = 4'b0000;
        reset = 1'b0;
        chk("rp_push0", 32'(bus.push[0]),   32'h0);
        chk("rp_pop0",  32'(bus.pop[0]),    32'h0);
        chk("rp_dpush", 32'(bus.D_push[0]), 32'h0);
        tick();
        chk("rp_push1", 32'(bus.push[0]), 32'h0);
        bus.pndng[0] = 4'b0011;
        tick();
        chk("rp_ptr0", 32'(bus.pop[0]), 32'b0001);

        // Winner withdraws its pending flag during POP: no pop, no push, back to IDLE
        bus.pndng[0] = 4'b0000;
        #1;
        chk("wd_pop", 32'(bus.pop[0]), 32'h0);
        tick();
        chk("wd_push", 32'(bus.push[0]), 32'h0);
        bus.pndng[0] = 4'b0011;
        tick();
        chk("wd_ptr_kept", 32'(bus.pop[0]), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
